// File: rtl/robot_pkg.sv
// Shared definitions for the robot link: move codes, motor drive levels,
// remote controller state encoding and the button-to-move encoder.
package robot_pkg;

    localparam logic [2:0] MOVE_STOP  = 3'b000;
    localparam logic [2:0] MOVE_FWD   = 3'b111;
    localparam logic [2:0] MOVE_LEFT  = 3'b101;
    localparam logic [2:0] MOVE_RIGHT = 3'b110;
    localparam logic [2:0] MOVE_BACK  = 3'b011;

    localparam logic MOTOR_OFF = 1'b0;
    localparam logic MOTOR_ON  = 1'b1;

    localparam int NUM_BTN   = 5;
    localparam int BTN_PWR   = 0;
    localparam int BTN_FWD   = 1;
    localparam int BTN_BACK  = 2;
    localparam int BTN_LEFT  = 3;
    localparam int BTN_RIGHT = 4;

    typedef enum logic [2:0] {
        ST_OFF,
        ST_WAIT_ON,
        ST_READY,
        ST_BLOCKED,
        ST_WAIT_OFF,
        ST_FAULT
    } rc_state_t;

    // Exactly one direction button selects its code; none or a chord means stop.
    function automatic logic [2:0] encode_move(input logic fwd, input logic back,
                                               input logic left, input logic right);
        logic [2:0] code;
        case ({fwd, back, left, right})
            4'b1000: code = MOVE_FWD;
            4'b0100: code = MOVE_BACK;
            4'b0010: code = MOVE_LEFT;
            4'b0001: code = MOVE_RIGHT;
            default: code = MOVE_STOP;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/remote_debounce.sv
// One button input: 2-FF synchronizer followed by a stability counter that
// only moves the debounced level after DEBOUNCE_CYCLES matching samples.
module remote_debounce
    import robot_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk_i,
    input  logic rstn_i,
    input  logic raw_i,
    output logic level_o
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            cnt     <= '0;
            level_o <= 1'b0;
        end else begin
            sync1 <= raw_i;
            sync2 <= sync1;
            // Any sample equal to the current level restarts the run.
            if (sync2 == level_o) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                level_o <= sync2;
                cnt     <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/remote_ctrl.sv
// Operator-side robot controller: debounced buttons, motor power handshake,
// obstacle blocking of forward motion and pult indicator LEDs.
module remote_ctrl
    import robot_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int ACK_TIMEOUT     = 64,
    parameter int BLOCK_HOLD      = 32,
    parameter int BLINK_HALF      = 8
) (
    input  logic       clk_i,
    input  logic       rstn_i,
    input  logic       btn_pwr_i,
    input  logic       btn_fwd_i,
    input  logic       btn_back_i,
    input  logic       btn_left_i,
    input  logic       btn_right_i,
    input  logic       motor_status_i,
    input  logic       tracker_status_i,
    output logic       motor_on_o,
    output logic [2:0] move_o,
    output logic       led_pwr_o,
    output logic       led_obstacle_o,
    output logic       led_fault_o
);

    localparam int TW = $clog2(ACK_TIMEOUT + 1);
    localparam int HW = $clog2(BLOCK_HOLD + 1);
    localparam int BW = $clog2(BLINK_HALF + 1);

    logic [NUM_BTN-1:0] btn_raw;
    logic [NUM_BTN-1:0] btn_db;

    assign btn_raw[BTN_PWR]   = btn_pwr_i;
    assign btn_raw[BTN_FWD]   = btn_fwd_i;
    assign btn_raw[BTN_BACK]  = btn_back_i;
    assign btn_raw[BTN_LEFT]  = btn_left_i;
    assign btn_raw[BTN_RIGHT] = btn_right_i;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_db
        remote_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
            .clk_i  (clk_i),
            .rstn_i (rstn_i),
            .raw_i  (btn_raw[i]),
            .level_o(btn_db[i])
        );
    end

    rc_state_t     state, state_nxt;
    logic          pwr_q;
    logic          pwr_evt;
    logic [2:0]    cmd;
    logic [TW-1:0] tmo_cnt;
    logic [HW-1:0] hold_cnt;
    logic [BW-1:0] blink_cnt;
    logic          tmo_done;
    logic          hold_done;
    logic          enter_wait;
    logic          enter_blocked;

    assign pwr_evt   = btn_db[BTN_PWR] & ~pwr_q;
    assign cmd       = encode_move(btn_db[BTN_FWD], btn_db[BTN_BACK],
                                   btn_db[BTN_LEFT], btn_db[BTN_RIGHT]);
    assign tmo_done  = (tmo_cnt == TW'(ACK_TIMEOUT - 1));
    assign hold_done = !tracker_status_i && (hold_cnt == HW'(BLOCK_HOLD - 1));

    assign enter_wait    = (state_nxt != state) &&
                           (state_nxt == ST_WAIT_ON || state_nxt == ST_WAIT_OFF);
    assign enter_blocked = (state_nxt == ST_BLOCKED) && (state != ST_BLOCKED);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_OFF:      if (pwr_evt) state_nxt = ST_WAIT_ON;
            ST_WAIT_ON: begin
                if (pwr_evt)             state_nxt = ST_WAIT_OFF;
                else if (motor_status_i) state_nxt = ST_READY;
                else if (tmo_done)       state_nxt = ST_FAULT;
            end
            ST_READY: begin
                if (pwr_evt)               state_nxt = ST_WAIT_OFF;
                else if (!motor_status_i)  state_nxt = ST_FAULT;
                else if (tracker_status_i) state_nxt = ST_BLOCKED;
            end
            ST_BLOCKED: begin
                if (pwr_evt)              state_nxt = ST_WAIT_OFF;
                else if (!motor_status_i) state_nxt = ST_FAULT;
                else if (hold_done)       state_nxt = ST_READY;
            end
            ST_WAIT_OFF: begin
                if (!motor_status_i) state_nxt = ST_OFF;
                else if (tmo_done)   state_nxt = ST_FAULT;
            end
            ST_FAULT:    if (pwr_evt) state_nxt = ST_WAIT_ON;
            default:     state_nxt = ST_OFF;
        endcase
    end

    // Outputs are registered from the next state so they change with the transition.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state          <= ST_OFF;
            pwr_q          <= 1'b0;
            tmo_cnt        <= '0;
            hold_cnt       <= '0;
            blink_cnt      <= '0;
            motor_on_o     <= MOTOR_OFF;
            move_o         <= MOVE_STOP;
            led_pwr_o      <= 1'b0;
            led_obstacle_o <= 1'b0;
            led_fault_o    <= 1'b0;
        end else begin
            state <= state_nxt;
            pwr_q <= btn_db[BTN_PWR];

            if (enter_wait)
                tmo_cnt <= '0;
            else if (tmo_cnt != TW'(ACK_TIMEOUT))
                tmo_cnt <= tmo_cnt + TW'(1);

            if (enter_blocked)
                hold_cnt <= '0;
            else if (state == ST_BLOCKED)
                hold_cnt <= tracker_status_i ? '0 : hold_cnt + HW'(1);

            if (enter_blocked) begin
                blink_cnt      <= '0;
                led_obstacle_o <= 1'b1;
            end else if (state_nxt == ST_BLOCKED) begin
                if (blink_cnt == BW'(BLINK_HALF - 1)) begin
                    blink_cnt      <= '0;
                    led_obstacle_o <= ~led_obstacle_o;
                end else begin
                    blink_cnt <= blink_cnt + BW'(1);
                end
            end else begin
                led_obstacle_o <= 1'b0;
            end

            motor_on_o <= (state_nxt == ST_WAIT_ON || state_nxt == ST_READY ||
                           state_nxt == ST_BLOCKED) ? MOTOR_ON : MOTOR_OFF;
            led_pwr_o   <= (state_nxt == ST_READY || state_nxt == ST_BLOCKED);
            led_fault_o <= (state_nxt == ST_FAULT);

            if (state_nxt == ST_READY)
                move_o <= cmd;
            else if (state_nxt == ST_BLOCKED)
                move_o <= (cmd == MOVE_FWD) ? MOVE_STOP : cmd;
            else
                move_o <= MOVE_STOP;
        end
    end

endmodule
